hq2x_buf_rd: RTL

HQ2X_BUF_RD -- requirements
Module: hq2x_buf_rd

---
 rtl/hq2x_pkg.sv | 13 +
 rtl/hq2x_skid.sv | 48 ++++
 rtl/hq2x_buf_rd.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hq2x_pkg.sv
// Shared definitions for the hq2x line-buffer reader: FSM state encoding
// and the depth of the skid FIFO that absorbs returned read data.
package hq2x_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/hq2x_skid.sv
// Two-entry skid FIFO holding buffer read words until the pixel consumer
// accepts them. Simultaneous push and pop leave the occupancy unchanged.
module hq2x_skid
  import hq2x_pkg::*;
#(
  parameter int DWIDTH = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DWIDTH:0]   push_data,
  input  logic              pop,
  output logic [DWIDTH:0]   pop_data,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DWIDTH:0] mem [FIFO_DEPTH];
  logic            wr_ptr;
  logic            rd_ptr;

  // Storage, pointers and occupancy; all cleared by the synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == 2'(FIFO_DEPTH));
  assign empty    = (count == 2'd0);

endmodule

// File: rtl/hq2x_buf_rd.sv
// hq2x line-buffer reader: on start, streams len words from base upward
// (address wraps modulo 2^(AWIDTH+1)) out of a 1-cycle-latency buffer and
// presents them as a valid/ready pixel stream.
// Optional build macro HQ2X_RD_HDOUBLE_EN: every pixel is presented twice
// (horizontal doubling); the FIFO entry is released after the second transfer.
//
// state | meaning
// IDLE  | waiting for start; first address is issued in the start cycle
// READ  | issuing the remaining addresses as FIFO space allows
// DRAIN | all addresses issued, emptying the FIFO to the consumer
module hq2x_buf_rd
  import hq2x_pkg::*;
#(
  parameter int AWIDTH = 14,
  parameter int DWIDTH = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AWIDTH:0]   base,
  input  logic [AWIDTH:0]   len,
  output logic [AWIDTH:0]   rdaddress,
  input  logic [DWIDTH:0]   q,
  output logic [DWIDTH:0]   px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [AWIDTH:0] ONE = {{AWIDTH{1'b0}}, 1'b1};

  state_t          state;
  state_t          state_nxt;
  logic [AWIDTH:0] last_addr;
  logic [AWIDTH:0] remaining;
  logic [AWIDTH:0] issue_addr;
  logic            inflight;
  logic            issue;
  logic            done_nxt;
  logic            xfer;
  logic            pop;
  logic            space;
  logic            last_pix;
  logic            fifo_full;
  logic            fifo_empty;
  logic [1:0]      fifo_count;
  logic [2:0]      occ;

  hq2x_skid #(.DWIDTH(DWIDTH)) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (q),
    .pop       (pop),
    .pop_data  (px_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign px_valid = !fifo_empty;
  assign xfer     = px_valid && px_ready;

`ifdef HQ2X_RD_HDOUBLE_EN
  logic phase;

  // Second-copy flag: toggles on every transfer, so the entry pops on odd ones.
  always_ff @(posedge clock) begin
    if (!reset_n)  phase <= 1'b0;
    else if (xfer) phase <= ~phase;
  end

  assign pop = xfer && phase;
`else
  assign pop = xfer;
`endif

  // A slot freed by this cycle's pop counts as space, which keeps the
  // stream bubble-free while never exceeding the two FIFO entries.
  assign occ        = {1'b0, fifo_count} + {2'b00, inflight};
  assign space      = ((occ < 3'd2) && !fifo_full) || pop;
  assign last_pix   = (state == DRAIN) && pop && (fifo_count == 2'd1) && !inflight;
  assign issue_addr = (state == IDLE) ? base : last_addr + ONE;
  assign rdaddress  = issue ? issue_addr : last_addr;
  assign busy       = (state != IDLE);

  // Next-state, address-issue and done decisions.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            issue     = 1'b1;
            state_nxt = READ;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      READ: begin
        if ((remaining != '0) && space) issue = 1'b1;
        if ((remaining == '0) || (issue && (remaining == ONE))) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_pix) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset_n) issue = 1'b0;
  end

  // State register, issue bookkeeping (down-counter of addresses left) and done pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      last_addr <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_nxt;
      done     <= done_nxt;
      inflight <= issue;
      if (issue) begin
        last_addr <= issue_addr;
        remaining <= (state == IDLE) ? len - ONE : remaining - ONE;
      end
    end
  end

endmodule
